// File: rtl/msgpack_pkg.sv
// Shared constants, FSM encoding and byte-length helpers for the MessagePack uint encoder.
package msgpack_pkg;

    localparam logic [7:0]  MP_UINT8      = 8'hCC;
    localparam logic [7:0]  MP_UINT16     = 8'hCD;
    localparam logic [7:0]  MP_UINT32     = 8'hCE;
    localparam logic [31:0] MP_FIXINT_MAX = 32'd127;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_t;

    // Total encoded length in bytes, prefix included.
    function automatic logic [2:0] byte_len(input logic [31:0] v);
        if (v <= MP_FIXINT_MAX) begin
            return 3'd1;
        end else if (v[31:8] == 24'd0) begin
            return 3'd2;
        end else if (v[31:16] == 16'd0) begin
            return 3'd3;
        end else begin
            return 3'd5;
        end
    endfunction

    function automatic logic [7:0] first_byte(input logic [31:0] v);
        case (byte_len(v))
            3'd1:    return v[7:0];
            3'd2:    return MP_UINT8;
            3'd3:    return MP_UINT16;
            default: return MP_UINT32;
        endcase
    endfunction

    // Payload byte to send when 'remaining' bytes (including this one) are left.
    function automatic logic [7:0] byte_at(input logic [31:0] v, input logic [2:0] remaining);
        case (remaining)
            3'd4:    return v[31:24];
            3'd3:    return v[23:16];
            3'd2:    return v[15:8];
            default: return v[7:0];
        endcase
    endfunction

endpackage

// File: rtl/fib_word_fifo.sv
// Synchronous word FIFO; extra pointer bit distinguishes full from empty.
module fib_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/fib_msgpack_encoder.sv
// Re-encodes fib result writes as minimal MessagePack uints on a valid/ready byte stream.
// Handshake: a byte transfers on a rising edge with o_valid && o_ready; while o_ready=0 the
// byte, o_last and o_valid hold steady, and o_valid never drops before its transfer.
module fib_msgpack_encoder
    import msgpack_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] RESULT_ADDR = 32'h0,
    parameter bit          ADDR_FILTER = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 addr_i,
    input  logic                        write_en_i,
    input  logic [31:0]                 data_i,
    output logic [7:0]                  o_data,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic                        o_last,
    output logic                        overflow_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic                        state_o
);

    enc_state_t  state;
    enc_state_t  state_nxt;
    logic [31:0] hold;
    logic [31:0] hold_nxt;
    logic [2:0]  count;
    logic [2:0]  count_nxt;
    logic [7:0]  data_nxt;
    logic        valid_nxt;
    logic        last_nxt;

    logic        accept;
    logic        handshake;
    logic        load_word;
    logic        fifo_push;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_rd_data;

    assign accept    = write_en_i && (!ADDR_FILTER || (addr_i == RESULT_ADDR));
    assign handshake = o_valid && o_ready;
    // A new word is taken when idle, or right as the final byte of the current word leaves.
    assign load_word = !fifo_empty &&
                       ((state == IDLE) || ((state == EMIT) && handshake && o_last));
    assign fifo_push = accept && (!fifo_full || load_word);
    assign state_o   = (state == EMIT);

    fib_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (load_word),
        .wr_data (data_i),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = EMIT;
            EMIT:    if (handshake && o_last && fifo_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hold_nxt  = hold;
        count_nxt = count;
        data_nxt  = o_data;
        valid_nxt = o_valid;
        last_nxt  = o_last;
        if (load_word) begin
            hold_nxt  = fifo_rd_data;
            count_nxt = byte_len(fifo_rd_data);
            data_nxt  = first_byte(fifo_rd_data);
            valid_nxt = 1'b1;
            last_nxt  = (byte_len(fifo_rd_data) == 3'd1);
        end else if ((state == EMIT) && handshake) begin
            if (o_last) begin
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end else begin
                count_nxt = count - 3'd1;
                data_nxt  = byte_at(hold, count - 3'd1);
                last_nxt  = (count == 3'd2);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold       <= '0;
            count      <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            hold    <= hold_nxt;
            count   <= count_nxt;
            o_data  <= data_nxt;
            o_valid <= valid_nxt;
            o_last  <= last_nxt;
            if (accept && fifo_full && !load_word) overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fib_msgpack_encoder.sv
// Directed and randomized bench for fib_msgpack_encoder with a byte-stream reference model.
module tb_fib_msgpack_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RADDR = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr_i = '0;
    logic        write_en_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic        o_last;
    logic        overflow_o;
    logic [2:0]  level_o;
    logic        state_o;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    int         hs_cyc[$];
    int         cycle = 0;
    int         pending = 0;
    int         max_level = 0;
    bit         mon_en = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle = cycle + 1;

    fib_msgpack_encoder #(
        .FIFO_DEPTH  (DEPTH),
        .RESULT_ADDR (RADDR),
        .ADDR_FILTER (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr_i),
        .write_en_i (write_en_i),
        .data_i     (data_i),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_last     (o_last),
        .overflow_o (overflow_o),
        .level_o    (level_o),
        .state_o    (state_o)
    );

    // Reference model: expected {last, byte} stream for one value.
    function automatic void push_exp(input logic [31:0] v);
        int         nb;
        logic [7:0] pfx;
        if (v < 32'd128) begin
            exp_q.push_back({1'b1, 8'(v)});
        end else begin
            if (v < 32'd256)        begin nb = 1; pfx = 8'hCC; end
            else if (v < 32'd65536) begin nb = 2; pfx = 8'hCD; end
            else                    begin nb = 4; pfx = 8'hCE; end
            exp_q.push_back({1'b0, pfx});
            for (int i = nb - 1; i >= 0; i--)
                exp_q.push_back({i == 0, 8'((v >> (8 * i)) % 256)});
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cycle(input logic [31:0] a, input logic [31:0] v, input bit kept);
        addr_i     = a;
        data_i     = v;
        write_en_i = 1'b1;
        if (kept) begin
            push_exp(v);
            pending++;
        end
        step();
        write_en_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        o_ready = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        step();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Stream monitor: compares each transferred byte with the model and checks hold-while-stalled.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                checks++;
                assert (o_valid === 1'b1 && o_data === prev_data && o_last === prev_last) else begin
                    errors++;
                    $error("FAIL stall_hold got=%0b/%0h/%0b exp=1/%0h/%0b",
                           o_valid, o_data, o_last, prev_data, prev_last);
                end
            end
            if (o_valid && o_ready) begin
                hs_cyc.push_back(cycle);
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_byte got=%0b/%0h exp=none", o_last, o_data);
                end
                if (exp_q.size() > 0) check("stream_byte", 32'({o_last, o_data}), 32'(exp_q.pop_front()));
                if (o_last && pending > 0) pending--;
            end
            prev_stall = o_valid && !o_ready;
            prev_data  = o_data;
            prev_last  = o_last;
            if (int'(level_o) > max_level) max_level = int'(level_o);
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int          n;
        int          c;
        logic [31:0] v;
        logic [31:0] a;

        // Reset values
        #12;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        step();

        // Single fixint with latency check
        o_ready    = 1'b1;
        addr_i     = RADDR;
        data_i     = 32'd8;
        write_en_i = 1'b1;
        push_exp(32'd8);
        pending++;
        step();
        write_en_i = 1'b0;
        check("lat_edge1_valid", 32'(o_valid), 32'd0);
        step();
        check("lat_edge2_valid", 32'(o_valid), 32'd1);
        check("lat_edge2_data", 32'(o_data), 32'h08);
        check("lat_edge2_last", 32'(o_last), 32'd1);
        drain("fixint_drain");

        // uint8 / uint16 / uint32 back to back
        hs_cyc.delete();
        write_cycle(RADDR, 32'd233, 1'b1);
        write_cycle(RADDR, 32'd46368, 1'b1);
        write_cycle(RADDR, 32'd832040, 1'b1);
        drain("multi_drain");
        check("multi_bytes", 32'(hs_cyc.size()), 32'd10);
        if (hs_cyc.size() == 10) check("multi_no_bubble", 32'(hs_cyc[9] - hs_cyc[0]), 32'd9);

        // Address filter
        max_level = 0;
        write_cycle(32'd1, 32'd5, 1'b0);
        write_cycle(RADDR, 32'd3, 1'b1);
        drain("filter_drain");
        check("filter_level_max", 32'(max_level <= 1), 32'd1);

        // o_ready toggling during a uint32
        o_ready = 1'b0;
        write_cycle(RADDR, 32'd832040, 1'b1);
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            o_ready = ~o_ready;
            step();
            n++;
        end
        drain("toggle_drain");

        // Randomized traffic, bounded outstanding so nothing may be dropped
        for (int i = 0; i < 80; i++) begin
            o_ready = ($urandom_range(0, 3) != 0);
            if (pending < 4 && $urandom_range(0, 1) == 1) begin
                c = $urandom_range(0, 3);
                case (c)
                    0:       v = $urandom_range(0, 127);
                    1:       v = $urandom_range(128, 255);
                    2:       v = $urandom_range(256, 65535);
                    default: v = $urandom_range(32'h10000, 32'hFFFF_FFFF);
                endcase
                a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 255)) : RADDR;
                write_cycle(a, v, a == RADDR);
            end else begin
                step();
            end
        end
        drain("random_drain");
        check("random_no_overflow", 32'(overflow_o), 32'd0);

        // Overflow: holding register plus DEPTH entries, the rest are dropped
        o_ready = 1'b0;
        for (int i = 1; i <= 6; i++) write_cycle(RADDR, 32'(i), i <= DEPTH + 1);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        check("ovf_level", 32'(level_o), 32'(DEPTH));
        check("ovf_head_data", 32'(o_data), 32'h01);
        drain("ovf_drain");
        check("ovf_sticky", 32'(overflow_o), 32'd1);

        // Reset in the middle of a uint16
        hs_cyc.delete();
        o_ready = 1'b1;
        write_cycle(RADDR, 32'd46368, 1'b1);
        n = 0;
        while (hs_cyc.size() < 2 && n < 20) begin
            step();
            n++;
        end
        check("midrst_bytes_seen", 32'(hs_cyc.size()), 32'd2);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_data", 32'(o_data), 32'd0);
        check("midrst_last", 32'(o_last), 32'd0);
        check("midrst_overflow", 32'(overflow_o), 32'd0);
        check("midrst_level", 32'(level_o), 32'd0);
        exp_q.delete();
        pending = 0;
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("postrst_idle_valid", 32'(o_valid), 32'd0);
        end
        write_cycle(RADDR, 32'd1, 1'b1);
        drain("postrst_drain");
        repeat (5) step();
        check("postrst_quiet_valid", 32'(o_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fib_msgpack_encoder.md
Name: fib_msgpack_encoder

Overview:
- Sits directly downstream of the fib core and consumes its result-write port (address, write enable, 32-bit data).
- Each accepted result word is re-encoded as a minimal-length MessagePack unsigned integer and emitted as a byte stream with valid/ready handshake, for the msgpack response path.
- An internal word FIFO absorbs results because the fib core has no back-pressure input.

Parameters:
- FIFO_DEPTH, 4, result-word FIFO depth; power of two, minimum 2.
- RESULT_ADDR, 32'h0, write address that carries a result.
- ADDR_FILTER, 1, 1 = accept only writes with addr_i == RESULT_ADDR; 0 = accept every write.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion is synchronous to clk at the source.
- addr_i  in  32  write address from fib core.
- write_en_i  in  1  write strobe from fib core, one cycle per result.
- data_i  in  32  result value from fib core.
- o_data  out  8  encoded byte.
- o_valid  out  1  o_data is valid.
- o_ready  in  1  downstream accepts the byte; transfer occurs when o_valid && o_ready at a rising edge.
- o_last  out  1  marks the final byte of one encoded value.
- overflow_o  out  1  sticky: a result was dropped because the FIFO was full.
- level_o  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values (rst=0, asynchronous): o_valid=0, o_last=0, o_data=0, overflow_o=0, level_o=0, FIFO emptied, FSM=IDLE.
- A reset mid-frame abandons the partial value; no byte is emitted after reset release until a new write arrives.
- Accept condition: write_en_i && (!ADDR_FILTER || addr_i==RESULT_ADDR).
  - Accepted data is pushed at that edge if the FIFO is not full.
  - If the FIFO is full and no pop happens in the same cycle, the word is dropped and overflow_o is set until reset.
- Full FIFO with simultaneous pop and push: both happen, nothing is dropped, level_o is unchanged.
- Non-accepted writes are ignored and have no side effects.
- Encoding of value v (bytes emitted big-endian):
  - v < 128: 1 byte, v[7:0].
  - v < 256: 0xCC, v[7:0].
  - v < 65536: 0xCD, v[15:8], v[7:0].
  - otherwise: 0xCE, v[31:24], v[23:16], v[15:8], v[7:0].
- FSM states:
  - IDLE: if the FIFO is not empty, pop the word into a 32-bit holding register, compute the byte count (1/2/3/5) into a 3-bit counter, load the first byte into o_data, set o_valid=1 and o_last=(count==1), then go to EMIT.
  - EMIT: o_data, o_last and o_valid are held stable while o_ready=0.
    - On a handshake with the counter above 1: load the next byte and decrement the counter.
    - On a handshake with o_last=1: if the FIFO is non-empty, load the next word in the same edge (back-to-back, no bubble) and stay in EMIT; otherwise o_valid=0 and go to IDLE.
- Latency: when idle with an empty FIFO, a write at edge t gives o_valid=1 after edge t+2 (one edge for the push, one for the pop/load).
- Throughput: 1 byte/cycle with o_ready held high.
- level_o counts FIFO entries only; the word in the holding register is not counted.
- No combinational path from any input to any output.

Decomposition:
- Shared package msgpack_pkg holds:
  - prefix constants MP_UINT8=8'hCC, MP_UINT16=8'hCD, MP_UINT32=8'hCE, MP_FIXINT_MAX=127;
  - FSM state encoding (IDLE, EMIT);
  - a byte-length function returning 1/2/3/5 for a 32-bit value.
- Sub-module fib_word_fifo:
  - synchronous FIFO of FIFO_DEPTH × 32, asynchronous active-low reset;
  - ports push/pop/full/empty/level;
  - pointer width clog2(DEPTH)+1 for full/empty disambiguation.
- The encoder FSM and holding register stay in the top module.

Test Plan:
- o_ready=1, accept write 8 (fib 6) -> one byte 0x08 with o_last=1, o_valid first seen two edges after the write.
- Writes 233, 46368, 832040 with o_ready=1:
  - 233 -> 0xCC 0xE9;
  - 46368 -> 0xCD 0xB5 0x20;
  - 832040 -> 0xCE 0x00 0x0C 0xB2 0x28;
  - o_last only on the final byte of each value; no bubble between values.
- ADDR_FILTER=1, RESULT_ADDR=0: writes of value 5 at addr 1 and value 3 at addr 0 -> only 0x03 emitted; level_o never exceeds 1.
- o_ready=0, six writes 1..6 with FIFO_DEPTH=4:
  - the first word sits in the holding register and 2..5 fill the FIFO;
  - word 6 is dropped, overflow_o=1, level_o=4;
  - releasing o_ready gives 0x01..0x05 in order; overflow_o stays 1.
- o_ready toggling every cycle during 832040 -> each of the 5 bytes is held stable until its handshake; the sequence is unchanged.
- Assert rst=0 after the second byte of 46368 -> all outputs are zero immediately; after release with no writes o_valid stays 0; a write of 1 then yields 0x01 alone.
